// File: rtl/move_scheduler_if.sv
// Collision-query channel between the move scheduler (master) and the playfield checker (slave).
interface move_scheduler_if;
    logic       chk_req;
    logic [7:0] chk_loc;
    logic       chk_rot;
    logic       chk_ack;
    logic       chk_collide;

    modport master (output chk_req, chk_loc, chk_rot, input chk_ack, chk_collide);
    modport slave  (input chk_req, chk_loc, chk_rot, output chk_ack, chk_collide);
endinterface

// File: rtl/move_scheduler.sv
// Arbitrates key and gravity requests for the falling piece and runs collision queries.
// Define SOFT_DROP_EN to shorten the gravity period to FALL_PERIOD/8 while soft_drop is high.
module move_scheduler #(
    parameter int unsigned FALL_PERIOD = 50000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [7:0]       location,
    input  logic             key_left,
    input  logic             key_right,
    input  logic             key_rotate,
    input  logic             key_drop,
    input  logic             soft_drop,
    move_scheduler_if.master chk,
    output logic             en_fall,
    output logic             move_valid,
    output logic [7:0]       location_move,
    output logic             rotate_go,
    output logic             done_tobottom,
    output logic [7:0]       location_tobottom,
    output logic             lock,
    output logic             busy
);

    localparam int unsigned CW = (FALL_PERIOD > 1) ? $clog2(FALL_PERIOD) : 1;
    localparam logic [CW-1:0] TERM_SLOW = CW'(FALL_PERIOD - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_QUERY  = 2'd1;
    localparam logic [1:0] ST_DROP_Q = 2'd2;
    localparam logic [1:0] ST_REPORT = 2'd3;

    localparam logic [1:0] RQ_FALL  = 2'd0;
    localparam logic [1:0] RQ_ROT   = 2'd1;
    localparam logic [1:0] RQ_LEFT  = 2'd2;
    localparam logic [1:0] RQ_RIGHT = 2'd3;

    localparam int unsigned P_RIGHT = 0;
    localparam int unsigned P_LEFT  = 1;
    localparam int unsigned P_ROT   = 2;
    localparam int unsigned P_FALL  = 3;
    localparam int unsigned P_DROP  = 4;

    logic [1:0]    state_q, state_d;
    logic [1:0]    rq_q, rq_d;
    logic [CW-1:0] cnt_q, cnt_d, term;
    logic          tick;
    logic [4:0]    pend_q, pend_d, pend_all;
    logic [7:0]    work_q, work_d;
    logic [7:0]    col;
    logic          chk_req_q, chk_req_d;
    logic [7:0]    chk_loc_q, chk_loc_d;
    logic          chk_rot_q, chk_rot_d;
    logic          fall_q, fall_d, move_q, move_d, rot_q, rot_d;
    logic          done_q, done_d, lock_q, lock_d;
    logic [7:0]    loc_move_q, loc_move_d, loc_bot_q, loc_bot_d;

`ifdef SOFT_DROP_EN
    localparam logic [CW-1:0] TERM_FAST = CW'(FALL_PERIOD / 8 - 1);
    assign term = soft_drop ? TERM_FAST : TERM_SLOW;
`else
    logic unused_soft_drop;
    assign unused_soft_drop = soft_drop;
    assign term = TERM_SLOW;
`endif

    // >= so that switching to the shorter period past its terminal count wraps at once
    assign tick = enable && (cnt_q >= term);
    assign col  = location % 8'd10;

    always_comb begin
        if (!enable || tick) cnt_d = '0;
        else                 cnt_d = cnt_q + CW'(1);
    end

    always_comb begin
        state_d    = state_q;
        rq_d       = rq_q;
        work_d     = work_q;
        chk_req_d  = chk_req_q;
        chk_loc_d  = chk_loc_q;
        chk_rot_d  = chk_rot_q;
        fall_d     = 1'b0;
        move_d     = 1'b0;
        rot_d      = 1'b0;
        done_d     = 1'b0;
        lock_d     = 1'b0;
        loc_move_d = loc_move_q;
        loc_bot_d  = loc_bot_q;
        pend_all   = pend_q | {key_drop, tick, key_rotate, key_left, key_right};
        pend_d     = pend_all;

        if (!enable) begin
            state_d   = ST_IDLE;
            chk_req_d = 1'b0;
            pend_d    = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pend_all[P_DROP]) begin
                        pend_d[P_DROP] = 1'b0;
                        if (location < 8'd10) begin
                            done_d    = 1'b1;
                            loc_bot_d = location;
                            state_d   = ST_REPORT;
                        end else begin
                            work_d    = location;
                            chk_req_d = 1'b1;
                            chk_loc_d = location - 8'd10;
                            chk_rot_d = 1'b0;
                            state_d   = ST_DROP_Q;
                        end
                    end else if (pend_all[P_FALL]) begin
                        pend_d[P_FALL] = 1'b0;
                        if (location < 8'd10) begin
                            lock_d = 1'b1;
                        end else begin
                            rq_d      = RQ_FALL;
                            chk_req_d = 1'b1;
                            chk_loc_d = location - 8'd10;
                            chk_rot_d = 1'b0;
                            state_d   = ST_QUERY;
                        end
                    end else if (pend_all[P_ROT]) begin
                        pend_d[P_ROT] = 1'b0;
                        rq_d          = RQ_ROT;
                        chk_req_d     = 1'b1;
                        chk_loc_d     = location;
                        chk_rot_d     = 1'b1;
                        state_d       = ST_QUERY;
                    end else if (pend_all[P_LEFT]) begin
                        pend_d[P_LEFT] = 1'b0;
                        if (col != 8'd0) begin
                            rq_d      = RQ_LEFT;
                            chk_req_d = 1'b1;
                            chk_loc_d = location - 8'd1;
                            chk_rot_d = 1'b0;
                            state_d   = ST_QUERY;
                        end
                    end else if (pend_all[P_RIGHT]) begin
                        pend_d[P_RIGHT] = 1'b0;
                        if (col != 8'd9) begin
                            rq_d      = RQ_RIGHT;
                            chk_req_d = 1'b1;
                            chk_loc_d = location + 8'd1;
                            chk_rot_d = 1'b0;
                            state_d   = ST_QUERY;
                        end
                    end
                end
                ST_QUERY: begin
                    if (chk.chk_ack) begin
                        chk_req_d = 1'b0;
                        chk_rot_d = 1'b0;
                        state_d   = ST_IDLE;
                        if (!chk.chk_collide) begin
                            unique case (rq_q)
                                RQ_FALL: fall_d = 1'b1;
                                RQ_ROT:  rot_d  = 1'b1;
                                RQ_LEFT, RQ_RIGHT: begin
                                    move_d     = 1'b1;
                                    loc_move_d = chk_loc_q;
                                end
                            endcase
                        end else if (rq_q == RQ_FALL) begin
                            lock_d = 1'b1;
                        end
                    end
                end
                ST_DROP_Q: begin
                    // Requests seen during a hard drop are meaningless once it lands
                    pend_d = '0;
                    if (chk.chk_ack) begin
                        if (chk.chk_collide || chk_loc_q < 8'd10) begin
                            done_d    = 1'b1;
                            loc_bot_d = chk.chk_collide ? work_q : chk_loc_q;
                            chk_req_d = 1'b0;
                            state_d   = ST_REPORT;
                        end else begin
                            work_d    = chk_loc_q;
                            chk_loc_d = chk_loc_q - 8'd10;
                        end
                    end
                end
                ST_REPORT: begin
                    pend_d  = '0;
                    lock_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rq_q       <= RQ_FALL;
            cnt_q      <= '0;
            pend_q     <= '0;
            work_q     <= '0;
            chk_req_q  <= 1'b0;
            chk_loc_q  <= '0;
            chk_rot_q  <= 1'b0;
            fall_q     <= 1'b0;
            move_q     <= 1'b0;
            rot_q      <= 1'b0;
            done_q     <= 1'b0;
            lock_q     <= 1'b0;
            loc_move_q <= 8'd194;
            loc_bot_q  <= 8'd194;
        end else begin
            state_q    <= state_d;
            rq_q       <= rq_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            work_q     <= work_d;
            chk_req_q  <= chk_req_d;
            chk_loc_q  <= chk_loc_d;
            chk_rot_q  <= chk_rot_d;
            fall_q     <= fall_d;
            move_q     <= move_d;
            rot_q      <= rot_d;
            done_q     <= done_d;
            lock_q     <= lock_d;
            loc_move_q <= loc_move_d;
            loc_bot_q  <= loc_bot_d;
        end
    end

    assign chk.chk_req       = chk_req_q;
    assign chk.chk_loc       = chk_loc_q;
    assign chk.chk_rot       = chk_rot_q;
    assign en_fall           = fall_q & enable;
    assign move_valid        = move_q & enable;
    assign rotate_go         = rot_q & enable;
    assign done_tobottom     = done_q & enable;
    assign lock              = lock_q & enable;
    assign location_move     = loc_move_q;
    assign location_tobottom = loc_bot_q;
    assign busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_move_scheduler.sv
// Scoreboard bench for move_scheduler: directed stimulus pushes expected events, a monitor pops them.
module tb_move_scheduler;

    typedef struct packed {
        logic [7:0] kind;
        logic [7:0] val;
    } ev_t;

`ifdef SOFT_DROP_EN
    localparam int SOFT_IV = 8;
`else
    localparam int SOFT_IV = 64;
`endif

    logic       clk = 1'b0;
    logic       rst_n, rst8;
    logic       enable;
    logic [7:0] location;
    logic       key_left, key_right, key_rotate, key_drop, soft_drop;
    logic       en_fall, move_valid, rotate_go, done_tobottom, lock, busy;
    logic [7:0] location_move, location_tobottom;

    logic       en_fall8, move_valid8, rotate_go8, done8, lock8, busy8;
    logic [7:0] location_move8, location_tobottom8;

    move_scheduler_if bus ();
    move_scheduler_if bus8 ();

    always #5 clk = ~clk;

    move_scheduler #(.FALL_PERIOD(64)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .location(location),
        .key_left(key_left), .key_right(key_right), .key_rotate(key_rotate),
        .key_drop(key_drop), .soft_drop(soft_drop), .chk(bus),
        .en_fall(en_fall), .move_valid(move_valid), .location_move(location_move),
        .rotate_go(rotate_go), .done_tobottom(done_tobottom),
        .location_tobottom(location_tobottom), .lock(lock), .busy(busy)
    );

    // Short-period instance exercising plain gravity on its own
    move_scheduler #(.FALL_PERIOD(8)) dut8 (
        .clk(clk), .rst_n(rst8), .enable(1'b1), .location(8'd94),
        .key_left(1'b0), .key_right(1'b0), .key_rotate(1'b0),
        .key_drop(1'b0), .soft_drop(1'b0), .chk(bus8),
        .en_fall(en_fall8), .move_valid(move_valid8), .location_move(location_move8),
        .rotate_go(rotate_go8), .done_tobottom(done8),
        .location_tobottom(location_tobottom8), .lock(lock8), .busy(busy8)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    ev_t        sb[$];
    int         q_cycles[$];
    int         ack_delay = 0;
    logic [255:0] cmap = '0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] k, input logic [7:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic got(input logic [7:0] k, input logic [7:0] v);
        ev_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got %s %0d, required none", k, v);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || e.val != v) begin
                n_bad++;
                $display("FAIL event: got %s %0d, required %s %0d", k, v, e.kind, e.val);
            end
        end
    endtask

    // Monitor and checker responder for the main instance
    int         cyc = 0;
    int         wcnt = 0;
    int         lock_due = -1;
    logic       prev_req = 1'b0, prev_ack = 1'b0, prev_rot = 1'b0;
    logic [7:0] prev_loc = '0;

    always @(negedge clk) begin
        int   np;
        logic a;
        cyc++;
        np = int'(en_fall) + int'(move_valid) + int'(rotate_go) + int'(done_tobottom) + int'(lock);
        if (np > 0) check("one_pulse", np, 1);
        if (lock_due == cyc) check("lock_after_done", int'(lock), 1);
        if (en_fall) got("F", 8'd0);
        if (move_valid) got("M", location_move);
        if (rotate_go) got("R", 8'd0);
        if (done_tobottom) begin
            got("D", location_tobottom);
            lock_due = cyc + 1;
        end
        if (lock) got("L", 8'd0);
        if (bus.chk_req && prev_req && !prev_ack) begin
            check("req_hold_loc", bus.chk_loc, prev_loc);
            check("req_hold_rot", int'(bus.chk_rot), int'(prev_rot));
        end
        a = 1'b0;
        if (bus.chk_req) begin
            if (wcnt >= ack_delay) begin
                a = 1'b1;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
        if (a) begin
            got(bus.chk_rot ? "T" : "Q", bus.chk_loc);
            q_cycles.push_back(cyc);
        end
        prev_req = bus.chk_req;
        prev_ack = a;
        prev_loc = bus.chk_loc;
        prev_rot = bus.chk_rot;
        bus.chk_ack     = a;
        bus.chk_collide = a & cmap[bus.chk_loc];
    end

    // Gravity-only instance: every query is 84, eight cycles apart, en_fall right after the ack
    int   c8 = 0;
    int   last8 = -1;
    logic a8;

    always @(negedge clk) begin
        c8++;
        if (en_fall8) check("fall8_pulse_after_ack", c8 - last8, 1);
        a8 = bus8.chk_req;
        if (a8) begin
            check("fall8_loc", bus8.chk_loc, 84);
            if (last8 >= 0) check("fall8_period", c8 - last8, 8);
            last8 = c8;
        end
        bus8.chk_ack     = a8;
        bus8.chk_collide = 1'b0;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int k);
        case (k)
            0: key_left = 1'b1;
            1: key_right = 1'b1;
            2: key_rotate = 1'b1;
            default: key_drop = 1'b1;
        endcase
        step(1);
        key_left = 1'b0;
        key_right = 1'b0;
        key_rotate = 1'b0;
        key_drop = 1'b0;
    endtask

    task automatic start(input logic [7:0] loc);
        enable = 1'b0;
        step(2);
        location = loc;
        enable = 1'b1;
    endtask

    task automatic flush(input string name);
        enable = 1'b0;
        step(2);
        check(name, sb.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        rst8 = 1'b0;
        enable = 1'b0;
        location = '0;
        key_left = 1'b0;
        key_right = 1'b0;
        key_rotate = 1'b0;
        key_drop = 1'b0;
        soft_drop = 1'b0;
        step(2);
        check("rst_chk_req", int'(bus.chk_req), 0);
        check("rst_chk_loc", bus.chk_loc, 0);
        check("rst_location_move", location_move, 194);
        check("rst_location_tobottom", location_tobottom, 194);
        check("rst_busy", int'(busy), 0);
        check("rst_pulses", int'({en_fall, move_valid, rotate_go, done_tobottom, lock}), 0);
        rst_n = 1'b1;
        rst8 = 1'b1;

        // Left at column 0 is discarded; right from 90 moves to 91
        start(8'd90);
        pulse(0);
        step(4);
        check("left_col0_busy", int'(busy), 0);
        push("Q", 8'd91);
        push("M", 8'd91);
        pulse(1);
        step(6);
        flush("sb_drained_lateral");

        // Hard drop from 54 landing on the collision at 14; a left during the drop is dropped
        start(8'd54);
        cmap[14] = 1'b1;
        push("Q", 8'd44);
        push("Q", 8'd34);
        push("Q", 8'd24);
        push("Q", 8'd14);
        push("D", 8'd24);
        push("L", 8'd0);
        pulse(3);
        step(1);
        pulse(0);
        step(10);
        cmap = '0;
        flush("sb_drained_drop");

        // Bottom row: gravity locks without a query; blocked rotation is silent
        start(8'd5);
        push("L", 8'd0);
        step(70);
        cmap[5] = 1'b1;
        push("T", 8'd5);
        pulse(2);
        step(6);
        cmap = '0;
        flush("sb_drained_bottom");

        // Slow checker: keys arriving mid-query are latched and serviced in priority order
        start(8'd55);
        ack_delay = 3;
        push("T", 8'd55);
        push("R", 8'd0);
        push("Q", 8'd54);
        push("M", 8'd54);
        push("Q", 8'd56);
        push("M", 8'd56);
        pulse(2);
        pulse(1);
        pulse(0);
        step(25);
        ack_delay = 0;
        flush("sb_drained_latched");

        // Asynchronous reset in the middle of an unanswered query
        start(8'd55);
        ack_delay = 1000;
        pulse(1);
        step(1);
        check("rstq_req_before", int'(bus.chk_req), 1);
        rst_n = 1'b0;
        #1;
        check("rstq_req_in_reset", int'(bus.chk_req), 0);
        check("rstq_location_move", location_move, 194);
        check("rstq_busy", int'(busy), 0);
        step(1);
        rst_n = 1'b1;
        ack_delay = 0;
        step(10);
        flush("sb_drained_reset");

        // enable low while a query waits for its ack
        start(8'd55);
        ack_delay = 1000;
        pulse(0);
        step(1);
        check("enlow_req_before", int'(bus.chk_req), 1);
        check("enlow_loc_before", bus.chk_loc, 54);
        check("enlow_busy_before", int'(busy), 1);
        enable = 1'b0;
        step(1);
        check("enlow_req_after", int'(bus.chk_req), 0);
        check("enlow_busy_after", int'(busy), 0);
        step(4);
        ack_delay = 0;
        check("sb_drained_enlow", sb.size(), 0);

        // Soft drop: gravity interval depends on SOFT_DROP_EN
        soft_drop = 1'b1;
        start(8'd94);
        q_cycles.delete();
        for (int i = 0; i < 3; i++) begin
            push("Q", 8'd84);
            push("F", 8'd0);
        end
        step(3 * SOFT_IV + 4);
        enable = 1'b0;
        soft_drop = 1'b0;
        check("soft_query_count", q_cycles.size(), 3);
        if (q_cycles.size() == 3) begin
            check("soft_interval_1", q_cycles[1] - q_cycles[0], SOFT_IV);
            check("soft_interval_2", q_cycles[2] - q_cycles[1], SOFT_IV);
        end
        flush("sb_drained_soft");

        check("fall8_seen", int'(last8 > 0), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/move_scheduler.md
MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 Parameter FALL_PERIOD, default 50000000, gravity interval in clk cycles (min 8).
REQ-002 clk  in  1  system clock, all logic on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 enable  in  1  high while a piece is in play; low flushes all activity.
REQ-005 location  in  8  current piece anchor, row*10+col, col 0..9.
REQ-006 key_left, key_right, key_rotate, key_drop  in  1 each  one-cycle request pulses.
REQ-007 soft_drop  in  1  accelerated-fall request level.
REQ-008 chk_req  out  1  collision query valid.
REQ-009 chk_loc  out  8  candidate anchor for the query.
REQ-010 chk_rot  out  1  candidate uses next rotation.
REQ-011 chk_ack  in  1  query answered this cycle.
REQ-012 chk_collide  in  1  answer, valid only with chk_ack.
REQ-013 en_fall  out  1  one-cycle pulse: drop piece one row.
REQ-014 move_valid / location_move  out  1 / 8  one-cycle pulse plus new anchor for lateral move.
REQ-015 rotate_go  out  1  one-cycle pulse: rotation legal.
REQ-016 done_tobottom / location_tobottom  out  1 / 8  one-cycle pulse plus landing anchor.
REQ-017 lock  out  1  one-cycle pulse: piece cannot fall further.
REQ-018 busy  out  1  high in any state except IDLE.

Function
REQ-019 Each key pulse sets a pending bit; repeated pulses while pending merge; bit clears when serviced or discarded.
REQ-020 Gravity counter counts 0..FALL_PERIOD-1 while enable, wraps, and sets fall-pending at terminal count.
REQ-021 States IDLE, QUERY, DROP_Q, REPORT; IDLE selects highest pending: drop > fall > rotate > left > right.
REQ-022 Candidates: fall location-10; left location-1; right location+1; rotate location with chk_rot=1.
REQ-023 Left with col 0, right with col 9: discarded in IDLE, no query, no output.
REQ-024 Fall with location<10: no query, lock pulses next cycle, fall-pending cleared.
REQ-025 Earliest query: chk_req high the cycle after the request pulse.
REQ-026 chk_req, chk_loc, chk_rot held stable from assertion until the cycle chk_ack is sampled high.
REQ-027 Ack without collide: corresponding pulse (en_fall, move_valid, rotate_go) in the next cycle, state returns IDLE.
REQ-028 Ack with collide: fall produces lock pulse; left/right/rotate produce no output.
REQ-029 Drop: working register = location; DROP_Q queries working-10 repeatedly, decrementing by 10 on each non-collide ack.
REQ-030 Drop ends on collide or working<10: done_tobottom with location_tobottom=working, then lock next cycle.
REQ-031 Drop completion clears fall-pending and all key pendings; keys arriving during drop are discarded.
REQ-032 Key pulses arriving during QUERY for another request are latched and serviced afterwards.
REQ-033 enable low: pendings cleared, counter to 0, state to IDLE next cycle, output pulses suppressed, chk_req dropped.
REQ-034 At most one of en_fall, move_valid, rotate_go, done_tobottom, lock high per cycle.

Reset
REQ-035 On rst_n low: state IDLE, counter 0, pendings 0, all pulse outputs and chk_req 0, chk_loc 0.
REQ-036 On rst_n low: location_move and location_tobottom 8'd194.
REQ-037 Reset mid-query abandons the query; no output pulse after release until a new request.

Configuration
REQ-038 Macro SOFT_DROP_EN defined: while soft_drop high, terminal count is FALL_PERIOD/8 - 1; counter >= new terminal wraps immediately.
REQ-039 SOFT_DROP_EN undefined: soft_drop ignored, terminal count always FALL_PERIOD-1.

Verification
REQ-040 FALL_PERIOD=8, location=94, ack no-collide: chk_loc=84 every 8 cycles, en_fall pulse after each ack.
REQ-041 location=90, key_left: no chk_req, no output; key_right: chk_loc=91, move_valid with location_move=91.
REQ-042 location=54, key_drop, collide only at 14: queries 44,34,24,14; done_tobottom with location_tobottom=24, lock next cycle.
REQ-043 location=5, fall tick: no query, lock pulse; key_rotate with collide: chk_rot=1, chk_loc=5, no rotate_go.
REQ-044 enable low mid-query, chk_ack withheld: chk_req drops next cycle, no pulses, busy 0.
REQ-045 SOFT_DROP_EN, FALL_PERIOD=64, soft_drop high: fall queries every 8 cycles; undefined: every 64.
